// File: rtl/data_memory_if.sv
// Bus between the load/store stage and the data RAM.
// There is no valid/ready handshake: write_enable qualifies a store on
// the next rising clock edge. read_data always returns the word selected
// by address, with no read strobe.
interface data_memory_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  write_enable;
  logic [31:0]           address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;

  // Load/store stage side
  modport master (
    output write_enable,
    output address,
    output write_data,
    input  read_data
  );

  // RAM side
  modport slave (
    input  write_enable,
    input  address,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/data_memory.sv
// Word-organized data RAM held in flip-flops so an asynchronous
// active-low reset can clear every word.
// Writes happen on the rising edge. Reads are combinational.
// Only the low ADDR_BITS bits of the address select a word, so higher
// addresses alias onto the same words.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  index;

  assign index = bus.address[ADDR_BITS-1:0];

  // Clear all words on reset. Otherwise store the selected word when
  // write_enable is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.write_enable) begin
      mem[index] <= bus.write_data;
    end
  end

  // Combinational read. There is no bypass, so a same-address write
  // becomes visible only after the edge.
  assign bus.read_data = mem[index];
endmodule

// File: tb/tb_data_memory.sv
// Directed testbench for data_memory: table-driven write/read vectors
// plus hand-written reset, read-during-write and reset-vs-write sequences.
module tb_data_memory;
  localparam int DW = 32;

  logic clk;
  logic rst_n;

  data_memory_if #(.DATA_WIDTH(DW)) bus ();

  data_memory #(.DATA_WIDTH(DW), .ADDR_BITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] exp);
    checks++;
    if (bus.read_data !== exp) begin
      errors++;
      $display("FAIL %s: addr=%0d got=%0d (0x%08h) expected=%0d (0x%08h)",
               name, bus.address, bus.read_data, bus.read_data, exp, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance past the next rising edge. Inputs are then driven and outputs
  // sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr,
                       input logic [DW-1:0] wd);
    bus.write_enable = we;
    bus.address      = addr;
    bus.write_data   = wd;
  endtask

  task automatic read_at(input logic [31:0] addr);
    bus.write_enable = 1'b0;
    bus.address      = addr;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;   // read_data at addr after the edge
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    // Basic writes, with write_enable dropped between them
    vecs[0]  = '{1'b1, 32'd3,  32'd45,  32'd45};
    vecs[1]  = '{1'b0, 32'd3,  32'd0,   32'd45};
    vecs[2]  = '{1'b1, 32'd5,  32'd78,  32'd78};
    vecs[3]  = '{1'b0, 32'd5,  32'd0,   32'd78};
    vecs[4]  = '{1'b1, 32'd7,  32'd123, 32'd123};
    vecs[5]  = '{1'b0, 32'd7,  32'd0,   32'd123};
    // Write disabled: data on the bus must not land
    vecs[6]  = '{1'b0, 32'd5,  32'd999, 32'd78};
    vecs[7]  = '{1'b0, 32'd5,  32'd999, 32'd78};
    vecs[8]  = '{1'b0, 32'd5,  32'd999, 32'd78};
    vecs[9]  = '{1'b0, 32'd3,  32'd999, 32'd45};
    // Top word and aliasing above the index width
    vecs[10] = '{1'b1, 32'd63, 32'd11,  32'd11};
    vecs[11] = '{1'b1, 32'd64, 32'd22,  32'd22};
    vecs[12] = '{1'b0, 32'd63, 32'd0,   32'd11};
    vecs[13] = '{1'b0, 32'd0,  32'd0,   32'd22};
    vecs[14] = '{1'b0, 32'd67, 32'd0,   32'd45};
    vecs[15] = '{1'b0, 32'hFFFF_FFC7, 32'd0, 32'd123};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, '0);
    #1;

    // Reset state
    read_at(32'd0);  check("reset_addr0", 32'd0);
    read_at(32'd17); check("reset_addr17", 32'd0);
    read_at(32'd63); check("reset_addr63", 32'd0);

    step();
    rst_n = 1'b1;

    // Reset clear: fill words 0, 3 and 63, then pulse reset between edges
    drive(1'b1, 32'd0,  32'hFFFF_FFFF); step();
    drive(1'b1, 32'd3,  32'hFFFF_FFFF); step();
    drive(1'b1, 32'd63, 32'hFFFF_FFFF); step();
    read_at(32'd0);  check("fill_addr0", 32'hFFFF_FFFF);
    read_at(32'd3);  check("fill_addr3", 32'hFFFF_FFFF);
    read_at(32'd63); check("fill_addr63", 32'hFFFF_FFFF);
    rst_n = 1'b0;
    read_at(32'd0);  check("async_clr_addr0", 32'd0);
    read_at(32'd3);  check("async_clr_addr3", 32'd0);
    read_at(32'd63); check("async_clr_addr63", 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_release_addr63", 32'd0);
    read_at(32'd0);  check("post_release_addr0", 32'd0);
    read_at(32'd3);  check("post_release_addr3", 32'd0);
    step();

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      exp_q.push_back(vecs[i].exp);
      step();
      check($sformatf("vec%0d", i), exp_q.pop_front());
    end
    // Word 3 must still hold 45 after the disabled-write vectors
    read_at(32'd3); check("word3_kept", 32'd45);

    // Read-during-write: old data before the edge, new data after
    drive(1'b1, 32'd3, 32'd200);
    #1;
    check("rdw_before_edge", 32'd45);
    step();
    check("rdw_after_edge", 32'd200);
    read_at(32'd5);  check("rdw_word5_untouched", 32'd78);
    read_at(32'd67); check("alias67_after_rdw", 32'd200);

    // Back-to-back writes to the same word: the last edge wins
    drive(1'b1, 32'd9, 32'd1); step();
    drive(1'b1, 32'd9, 32'd2); step();
    read_at(32'd9); check("b2b_last_wins", 32'd2);

    // Reset vs write: reset held across an edge with a write pending
    step();
    drive(1'b1, 32'd7, 32'd55);
    rst_n = 1'b0;
    step();
    check("rst_vs_write_during", 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_vs_write_released", 32'd0);
    bus.write_data = 32'd77;
    step();
    check("first_write_after_release", 32'd77);
    read_at(32'd3); check("word3_cleared", 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
